// File: rtl/hybrid_control_pipelined.sv
// Pipelined hybrid controller for the resonant converter: evaluates the three jump
// half-planes from (vC, iC) and drives the 4-state sigma automaton and gate commands.
module hybrid_control_pipelined #(
  parameter int DATA_W    = 14,
  parameter int TRIG_W    = 16,
  parameter int COEF_W    = 32,
  parameter logic signed [COEF_W-1:0] MU_X1 = COEF_W'(86),
  parameter logic signed [COEF_W-1:0] MU_X2 = COEF_W'(90),
  parameter logic signed [COEF_W-1:0] MU_VG = COEF_W'(312000),
  parameter int MIN_DWELL = 8,
  parameter int CNT_W     = 16
) (
  input  logic                     i_clock,
  input  logic                     i_RESET,
  input  logic                     i_enable,
  input  logic                     i_three_level,
  input  logic signed [DATA_W-1:0] i_vC,
  input  logic signed [DATA_W-1:0] i_iC,
  input  logic signed [TRIG_W-1:0] i_sin_p,
  input  logic signed [TRIG_W-1:0] i_cos_p,
  input  logic signed [TRIG_W-1:0] i_sin_m,
  input  logic signed [TRIG_W-1:0] i_cos_m,
  output logic [3:0]               o_MOSFET,
  output logic [1:0]               o_sigma,
  output logic                     o_jump,
  output logic [CNT_W-1:0]         o_jump_cnt,
  output logic [7:0]               o_debug
);

  localparam int ZW = COEF_W + DATA_W + 2;
  localparam int PW = ZW + TRIG_W;
  localparam int SW = PW + 2;
  localparam int DW = $clog2(MIN_DWELL + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);

  typedef enum logic [1:0] {ST_POS = 2'b00, ST_ZA = 2'b01, ST_NEG = 2'b10, ST_ZB = 2'b11} state_t;

  state_t                   r_state;
  logic [DW-1:0]            r_dwell;
  logic [3:0]               r_mos;
  logic [1:0]               r_sigma;
  logic                     r_jump;
  logic [CNT_W-1:0]         r_cnt;

  logic signed [DATA_W-1:0] r_vc_p0, r_ic_p0;
  logic signed [TRIG_W-1:0] r_sinp_p0, r_cosp_p0, r_sinm_p0, r_cosm_p0;
  logic signed [ZW-1:0]     r_z1_p1, r_z2_p1;
  logic signed [PW-1:0]     r_c_p1;
  logic signed [TRIG_W-1:0] r_sinp_p1, r_cosp_p1, r_sinm_p1, r_cosm_p1;
  logic signed [PW-1:0]     r_a_p2, r_b_p2, r_d_p2, r_e_p2, r_c_p2;
  logic                     r_c1, r_c2, r_c3, r_c4;

  logic signed [ZW-1:0]     w_sig_vg;
  logic signed [SW-1:0]     w_s1, w_s2, w_s3;
  logic                     w_active, w_dwell_ok, w_jump;
  state_t                   w_next;

  function automatic logic [3:0] mos_of(input state_t s);
    case (s)
      ST_POS:  mos_of = 4'b1001;
      ST_NEG:  mos_of = 4'b0110;
      default: mos_of = 4'b0011;
    endcase
  endfunction

  function automatic logic [1:0] sigma_of(input state_t s);
    case (s)
      ST_POS:  sigma_of = 2'b01;
      ST_NEG:  sigma_of = 2'b11;
      default: sigma_of = 2'b00;
    endcase
  endfunction

  // Stage 1: sample ADC and trig inputs
  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      r_vc_p0   <= '0;
      r_ic_p0   <= '0;
      r_sinp_p0 <= '0;
      r_cosp_p0 <= '0;
      r_sinm_p0 <= '0;
      r_cosm_p0 <= '0;
    end else begin
      r_vc_p0   <= i_vC;
      r_ic_p0   <= i_iC;
      r_sinp_p0 <= i_sin_p;
      r_cosp_p0 <= i_cos_p;
      r_sinm_p0 <= i_sin_m;
      r_cosm_p0 <= i_cos_m;
    end
  end

  always_comb begin
    w_sig_vg = '0;
    case (r_state)
      ST_POS:  w_sig_vg = ZW'(MU_VG);
      ST_NEG:  w_sig_vg = -ZW'(MU_VG);
      default: w_sig_vg = '0;
    endcase
  end

  // Stage 2: scaled coordinates; sigma is the automaton state seen at this edge
  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      r_z1_p1   <= '0;
      r_z2_p1   <= '0;
      r_c_p1    <= '0;
      r_sinp_p1 <= '0;
      r_cosp_p1 <= '0;
      r_sinm_p1 <= '0;
      r_cosm_p1 <= '0;
    end else begin
      r_z1_p1   <= ZW'(MU_X1) * ZW'(r_vc_p0) - w_sig_vg;
      r_z2_p1   <= ZW'(MU_X2) * ZW'(r_ic_p0);
      r_c_p1    <= PW'(MU_VG) * PW'(r_sinm_p0);
      r_sinp_p1 <= r_sinp_p0;
      r_cosp_p1 <= r_cosp_p0;
      r_sinm_p1 <= r_sinm_p0;
      r_cosm_p1 <= r_cosm_p0;
    end
  end

  // Stage 3: rotation products
  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      r_a_p2 <= '0;
      r_b_p2 <= '0;
      r_d_p2 <= '0;
      r_e_p2 <= '0;
      r_c_p2 <= '0;
    end else begin
      r_a_p2 <= PW'(r_z1_p1) * PW'(r_sinm_p1);
      r_b_p2 <= PW'(r_z2_p1) * PW'(r_cosm_p1);
      r_d_p2 <= PW'(r_z1_p1) * PW'(r_sinp_p1);
      r_e_p2 <= PW'(r_z2_p1) * PW'(r_cosp_p1);
      r_c_p2 <= r_c_p1;
    end
  end

  assign w_s1 = SW'(r_a_p2) + SW'(r_b_p2) + SW'(r_c_p2);
  assign w_s2 = SW'(r_d_p2) + SW'(r_e_p2);
  assign w_s3 = SW'(r_a_p2) + SW'(r_b_p2) - SW'(r_c_p2);

  // Stage 4: half-plane sign flags
  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      r_c1 <= 1'b0;
      r_c2 <= 1'b0;
      r_c3 <= 1'b0;
      r_c4 <= 1'b0;
    end else begin
      r_c1 <= ~w_s1[SW-1];
      r_c2 <= ~w_s2[SW-1];
      r_c3 <= w_s3[SW-1];
      r_c4 <= w_s2[SW-1];
    end
  end

  always_comb begin
    w_active = 1'b0;
    case (r_state)
      ST_POS:  w_active = r_c1;
      ST_ZA:   w_active = r_c2;
      ST_NEG:  w_active = r_c3;
      default: w_active = r_c4;
    endcase
  end

  // 2-level mode skips the zero states: from 00/01 go to 10, from 10/11 go to 00
  always_comb begin
    w_next = r_state;
    if (i_three_level) w_next = state_t'(r_state + 2'd1);
    else               w_next = r_state[1] ? ST_POS : ST_NEG;
  end

  assign w_dwell_ok = (r_dwell == DWELL_MAX);
  assign w_jump     = i_enable & w_dwell_ok & w_active;

  // Automaton and registered gate outputs
  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      r_state <= ST_POS;
      r_dwell <= '0;
      r_mos   <= 4'b0000;
      r_sigma <= 2'b01;
      r_jump  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_mos   <= i_enable ? mos_of(r_state) : 4'b0000;
      r_sigma <= i_enable ? sigma_of(r_state) : 2'b01;
      r_jump  <= w_jump;
      if (!i_enable) begin
        r_state <= ST_POS;
        r_dwell <= '0;
      end else if (w_jump) begin
        r_state <= w_next;
        r_dwell <= '0;
        r_cnt   <= r_cnt + CNT_W'(1);
      end else if (!w_dwell_ok) begin
        r_dwell <= r_dwell + DW'(1);
      end
    end
  end

  assign o_MOSFET   = r_mos;
  assign o_sigma    = r_sigma;
  assign o_jump     = r_jump;
  assign o_jump_cnt = r_cnt;
  assign o_debug    = {r_c4, r_c3, r_c2, r_c1, w_dwell_ok, r_jump, r_state};

endmodule

// File: tb/tb_hybrid_control_pipelined.sv
// Scoreboard bench for hybrid_control_pipelined: a plain-arithmetic reference model
// predicts every cycle's outputs; a monitor compares them one cycle after each edge.
module tb_hybrid_control_pipelined;

  localparam int DATA_W    = 14;
  localparam int TRIG_W    = 16;
  localparam int CNT_W     = 4;
  localparam int MIN_DWELL = 8;
  localparam longint MX1 = 86;
  localparam longint MX2 = 90;
  localparam longint MVG = 312000;
  localparam int HN = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, en = 1'b0, tl = 1'b1;
  logic signed [DATA_W-1:0] vc = '0, ic = '0;
  logic signed [TRIG_W-1:0] sp = '0, cp = '0, sm = '0, cm = '0;
  logic [3:0]       o_MOSFET;
  logic [1:0]       o_sigma;
  logic             o_jump;
  logic [CNT_W-1:0] o_jump_cnt;
  logic [7:0]       o_debug;

  hybrid_control_pipelined #(.CNT_W(CNT_W), .MIN_DWELL(MIN_DWELL)) dut (
    .i_clock(clk), .i_RESET(rst), .i_enable(en), .i_three_level(tl),
    .i_vC(vc), .i_iC(ic), .i_sin_p(sp), .i_cos_p(cp), .i_sin_m(sm), .i_cos_m(cm),
    .o_MOSFET(o_MOSFET), .o_sigma(o_sigma), .o_jump(o_jump),
    .o_jump_cnt(o_jump_cnt), .o_debug(o_debug)
  );

  typedef struct {
    logic [3:0]       mos;
    logic [1:0]       sig;
    logic             jmp;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       dbg;
  } exp_t;

  exp_t q[$];
  exp_t mon_x;
  int tests = 0, fails = 0;
  int mon_cyc = 0;

  // reference model state
  int m_state = 0, m_dwell = 0, m_cnt = 0;
  int n = 0, r_last = 0;
  longint h_vc[HN], h_ic[HN], h_sp[HN], h_cp[HN], h_sm[HN], h_cm[HN];
  int h_st[HN];
  int s_vc, s_ic, s_sp, s_cp, s_sm, s_cm;

  function automatic logic [3:0] mos_tab(input int s);
    case (s)
      0: return 4'b1001;
      2: return 4'b0110;
      default: return 4'b0011;
    endcase
  endfunction

  function automatic logic [1:0] sig_tab(input int s);
    case (s)
      0: return 2'b01;
      2: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Half-plane test for current state st using the sample and state recorded at slot k
  function automatic bit active_flag(input int st, input int k);
    longint sg, z1, z2, c, s1, s2, s3;
    sg = (h_st[k] == 0) ? 1 : (h_st[k] == 2) ? -1 : 0;
    z1 = MX1 * h_vc[k] - sg * MVG;
    z2 = MX2 * h_ic[k];
    c  = MVG * h_sm[k];
    s1 = z1 * h_sm[k] + z2 * h_cm[k] + c;
    s2 = z1 * h_sp[k] + z2 * h_cp[k];
    s3 = z1 * h_sm[k] + z2 * h_cm[k] - c;
    case (st)
      0: return s1 >= 0;
      1: return s2 >= 0;
      2: return s3 < 0;
      default: return s2 < 0;
    endcase
  endfunction

  task automatic cycle(input logic r, input logic e, input logic t);
    exp_t x;
    int idx, prev;
    bit dok, fl, jmp;
    @(negedge clk);
    rst = r; en = e; tl = t;
    vc = s_vc[DATA_W-1:0]; ic = s_ic[DATA_W-1:0];
    sp = s_sp[TRIG_W-1:0]; cp = s_cp[TRIG_W-1:0];
    sm = s_sm[TRIG_W-1:0]; cm = s_cm[TRIG_W-1:0];
    n++;
    idx = n % HN;
    h_vc[idx] = s_vc; h_ic[idx] = s_ic; h_sp[idx] = s_sp;
    h_cp[idx] = s_cp; h_sm[idx] = s_sm; h_cm[idx] = s_cm;
    if (r) begin
      m_state = 0; m_dwell = 0; m_cnt = 0; r_last = n;
      x.mos = 4'b0000; x.sig = 2'b01; x.jmp = 1'b0; x.cnt = '0; x.dbg = 4'b0000;
    end else begin
      prev  = m_state;
      x.mos = e ? mos_tab(prev) : 4'b0000;
      x.sig = e ? sig_tab(prev) : 2'b01;
      dok   = (m_dwell == MIN_DWELL);
      fl    = (n - 4 >= r_last + 1) ? active_flag(prev, (n - 4) % HN) : 1'b0;
      jmp   = e && dok && fl;
      if (!e) begin
        m_state = 0; m_dwell = 0;
      end else if (jmp) begin
        m_state = t ? (prev + 1) % 4 : ((prev == 0 || prev == 1) ? 2 : 0);
        m_dwell = 0;
        m_cnt   = (m_cnt + 1) % (1 << CNT_W);
      end else if (m_dwell < MIN_DWELL) begin
        m_dwell++;
      end
      x.jmp = jmp;
      x.cnt = m_cnt[CNT_W-1:0];
      x.dbg = {(m_dwell == MIN_DWELL), jmp, m_state[1:0]};
    end
    h_st[idx] = m_state;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic set_static(input int v, input int i, input int s_p, input int c_p,
                            input int s_m, input int c_m);
    s_vc = v; s_ic = i; s_sp = s_p; s_cp = c_p; s_sm = s_m; s_cm = c_m;
  endtask

  // Monitor: pops one prediction per edge and compares the full output set
  always @(posedge clk) begin
    #1;
    mon_cyc++;
    if (q.size() > 0) begin
      mon_x = q.pop_front();
      tests++;
      if (o_MOSFET !== mon_x.mos || o_sigma !== mon_x.sig || o_jump !== mon_x.jmp ||
          o_jump_cnt !== mon_x.cnt || o_debug[3:0] !== mon_x.dbg) begin
        fails++;
        $display("FAIL scoreboard cyc=%0d mos=%b/%b sig=%b/%b jump=%b/%b cnt=%0d/%0d dbg=%b/%b (actual/required)",
                 mon_cyc, o_MOSFET, mon_x.mos, o_sigma, mon_x.sig, o_jump, mon_x.jmp,
                 o_jump_cnt, mon_x.cnt, o_debug[3:0], mon_x.dbg);
      end
    end
  end

  initial begin
    int first, jc, last_j, cyc;
    set_static(0, 0, 16384, 0, 16384, 0);

    // reset state
    repeat (3) cycle(1'b1, 1'b0, 1'b1);
    chk("reset_mos", 32'(o_MOSFET), 32'h0);
    chk("reset_sigma", 32'(o_sigma), 32'h1);
    chk("reset_debug", 32'(o_debug), 32'h0);

    // 3-level: 00 -> 01 -> 10, then holds
    first = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle(1'b0, 1'b1, 1'b1);
      if (o_jump && first == 0) first = i;
    end
    chk("t2_first_jump", 32'(first), 32'd9);
    chk("t2_cnt", 32'(o_jump_cnt), 32'd2);
    chk("t2_mos", 32'(o_MOSFET), 32'b0110);
    chk("t2_state", 32'(o_debug[1:0]), 32'd2);

    // reset held mid-run
    repeat (3) cycle(1'b1, 1'b1, 1'b1);
    chk("t1_mos", 32'(o_MOSFET), 32'h0);
    chk("t1_sigma", 32'(o_sigma), 32'h1);
    chk("t1_cnt", 32'(o_jump_cnt), 32'h0);
    chk("t1_state", 32'(o_debug[1:0]), 32'h0);

    // 2-level: 00 -> 10 then holds
    repeat (30) cycle(1'b0, 1'b1, 1'b0);
    chk("t3_sigma", 32'(o_sigma), 32'b11);
    chk("t3_cnt", 32'(o_jump_cnt), 32'd1);
    chk("t3_mos", 32'(o_MOSFET), 32'b0110);

    // enable drop in state 10, then re-enable
    cycle(1'b0, 1'b0, 1'b0);
    chk("t5_off_mos", 32'(o_MOSFET), 32'h0);
    chk("t5_off_state", 32'(o_debug[1:0]), 32'h0);
    chk("t5_off_sigma", 32'(o_sigma), 32'h1);
    jc = 0;
    cycle(1'b0, 1'b1, 1'b0);
    chk("t5_on_mos", 32'(o_MOSFET), 32'b1001);
    jc += int'(o_jump);
    repeat (7) begin
      cycle(1'b0, 1'b1, 1'b0);
      jc += int'(o_jump);
    end
    chk("t5_no_early_jump", 32'(jc), 32'd0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("t5_jump_at_9", 32'(o_jump), 32'd1);

    // active flag kept true: jumps every MIN_DWELL+1 cycles, counter wraps
    repeat (2) cycle(1'b1, 1'b1, 1'b0);
    jc = 0; last_j = 0; cyc = 0;
    for (int i = 0; i < 160; i++) begin
      set_static((m_state == 0) ? 100 : -100, 0, 0, 0, 16384, 0);
      cycle(1'b0, 1'b1, 1'b0);
      cyc++;
      if (o_jump) begin
        jc++;
        if (last_j > 0) chk("t4_interval", 32'(cyc - last_j), 32'(MIN_DWELL + 1));
        last_j = cyc;
      end
    end
    chk("t6_pulses", 32'(jc), 32'd17);
    chk("t6_cnt_wrap", 32'(o_jump_cnt), 32'd1);

    // randomized run against the reference model
    repeat (800) begin
      set_static($urandom_range(4000) - 2000, $urandom_range(4000) - 2000,
                 $urandom_range(32768) - 16384, $urandom_range(32768) - 16384,
                 $urandom_range(32768) - 16384, $urandom_range(32768) - 16384);
      if ($urandom_range(49) == 0) tl = ~tl;
      cycle(($urandom_range(99) == 0), ($urandom_range(9) != 0), tl);
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
